// File: rtl/fp_reg_file_if.sv
// rtl/fp_reg_file_if.sv - operand/result/flag bundle between FP register file and its user
// The master side drives indices, write data and flag inputs; the slave side returns operands and flags.
interface fp_reg_file_if #(
    parameter int AW   = 5,
    parameter int WORD = 32
);
    logic                inst_valid;
    logic [AW-1:0]       rd_addr1;
    logic [AW-1:0]       rd_addr2;
    logic                dp;
    logic [2*WORD-1:0]   rd_data1;
    logic [2*WORD-1:0]   rd_data2;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [2*WORD-1:0]   wr_data;
    logic                cond_wr;
    logic                cond_in;
    logic                fpcond;
    logic                err_align;

    modport master (
        output inst_valid, rd_addr1, rd_addr2, dp, wr_en, wr_addr, wr_data, cond_wr, cond_in,
        input  rd_data1, rd_data2, fpcond, err_align
    );

    modport slave (
        input  inst_valid, rd_addr1, rd_addr2, dp, wr_en, wr_addr, wr_data, cond_wr, cond_in,
        output rd_data1, rd_data2, fpcond, err_align
    );
endinterface

// File: rtl/fp_reg_file.sv
// rtl/fp_reg_file.sv - coprocessor-1 register bank with FP condition flag and DP alignment error
// Reads are combinational and see pre-edge contents; a DP access pairs even (high) with odd (low).
module fp_reg_file #(
    parameter int AW   = 5,
    parameter int WORD = 32
) (
    input  logic          clk,
    input  logic          rst,
    fp_reg_file_if.slave  bus
);
    localparam int DEPTH = 2 ** AW;

    logic [WORD-1:0] regs_q [DEPTH];
    logic [WORD-1:0] regs_d [DEPTH];
    logic            fpcond_q;
    logic            fpcond_d;
    logic            err_align_q;
    logic            err_align_d;

    // Forcing the LSB keeps a DP pair inside the bank, so base+1 never wraps.
    logic [AW-1:0] rd1_even, rd1_odd, rd2_even, rd2_odd, wr_even, wr_odd;

    assign rd1_even = {bus.rd_addr1[AW-1:1], 1'b0};
    assign rd1_odd  = {bus.rd_addr1[AW-1:1], 1'b1};
    assign rd2_even = {bus.rd_addr2[AW-1:1], 1'b0};
    assign rd2_odd  = {bus.rd_addr2[AW-1:1], 1'b1};
    assign wr_even  = {bus.wr_addr[AW-1:1], 1'b0};
    assign wr_odd   = {bus.wr_addr[AW-1:1], 1'b1};

    always_comb begin
        if (bus.dp) begin
            bus.rd_data1 = {regs_q[rd1_even], regs_q[rd1_odd]};
            bus.rd_data2 = {regs_q[rd2_even], regs_q[rd2_odd]};
        end else begin
            bus.rd_data1 = {regs_q[bus.rd_addr1], {WORD{1'b0}}};
            bus.rd_data2 = {regs_q[bus.rd_addr2], {WORD{1'b0}}};
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (bus.wr_en) begin
            if (bus.dp) begin
                regs_d[wr_even] = bus.wr_data[2*WORD-1:WORD];
                regs_d[wr_odd]  = bus.wr_data[WORD-1:0];
            end else begin
                regs_d[bus.wr_addr] = bus.wr_data[2*WORD-1:WORD];
            end
        end
    end

    always_comb begin
        fpcond_d    = bus.cond_wr ? bus.cond_in : fpcond_q;
        err_align_d = err_align_q |
                      (bus.inst_valid & bus.dp &
                       (bus.rd_addr1[0] | bus.rd_addr2[0] | (bus.wr_en & bus.wr_addr[0])));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q      <= '{default: '0};
            fpcond_q    <= 1'b0;
            err_align_q <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            fpcond_q    <= fpcond_d;
            err_align_q <= err_align_d;
        end
    end

    assign bus.fpcond    = fpcond_q;
    assign bus.err_align = err_align_q;
endmodule

// File: tb/tb_fp_reg_file.sv
// tb/tb_fp_reg_file.sv - directed vector bench for fp_reg_file
// Each vector is one cycle: inputs driven after negedge, outputs compared before the next posedge.
module tb_fp_reg_file;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fp_reg_file_if #(.AW(5), .WORD(32)) bus ();

    fp_reg_file #(.AW(5), .WORD(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rst;
        logic        iv;
        logic        dp;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic        we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic        cw;
        logic        ci;
        logic        chk;
        logic [63:0] e1;
        logic [63:0] e2;
        logic        ef;
        logic        ee;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic vec_t mk(input logic r, input logic iv, input logic dp,
                                input logic [4:0] a1, input logic [4:0] a2,
                                input logic we, input logic [4:0] wa, input logic [63:0] wd,
                                input logic cw, input logic ci, input logic chk,
                                input logic [63:0] e1, input logic [63:0] e2,
                                input logic ef, input logic ee);
        vec_t v;
        v.rst = r;  v.iv = iv; v.dp = dp; v.a1 = a1; v.a2 = a2;
        v.we  = we; v.wa = wa; v.wd = wd; v.cw = cw; v.ci = ci;
        v.chk = chk; v.e1 = e1; v.e2 = e2; v.ef = ef; v.ee = ee;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        rst            = v.rst;
        bus.inst_valid = v.iv;
        bus.dp         = v.dp;
        bus.rd_addr1   = v.a1;
        bus.rd_addr2   = v.a2;
        bus.wr_en      = v.we;
        bus.wr_addr    = v.wa;
        bus.wr_data    = v.wd;
        bus.cond_wr    = v.cw;
        bus.cond_in    = v.ci;
        #1;
        if (v.chk) begin
            check("rd_data1", idx, bus.rd_data1, v.e1);
            check("rd_data2", idx, bus.rd_data2, v.e2);
            check("fpcond", idx, {63'b0, bus.fpcond}, {63'b0, v.ef});
            check("err_align", idx, {63'b0, bus.err_align}, {63'b0, v.ee});
        end
    endtask

    vec_t tbl [19];

    initial begin
        // rst iv dp a1 a2 we wa wd cw ci chk e1 e2 ef ee
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 64'h0, 0, 0, 0, 64'h0, 64'h0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 3, 0, 1, 3, 64'h3F800000_DEADBEEF, 0, 0, 1, 64'h0, 64'h0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 3, 2, 0, 0, 64'h0, 0, 0, 1, 64'h3F800000_00000000, 64'h0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 4, 3, 0, 0, 64'h0, 0, 0, 1, 64'h0, 64'h3F800000_00000000, 0, 0);
        tbl[4]  = mk(0, 0, 1, 4, 2, 1, 4, 64'h400921FB_54442D18, 0, 0, 1,
                     64'h0, 64'h00000000_3F800000, 0, 0);
        tbl[5]  = mk(0, 0, 1, 4, 2, 0, 0, 64'h0, 0, 0, 1,
                     64'h400921FB_54442D18, 64'h00000000_3F800000, 0, 0);
        tbl[6]  = mk(0, 0, 0, 5, 4, 0, 0, 64'h0, 0, 0, 1,
                     64'h54442D18_00000000, 64'h400921FB_00000000, 0, 0);
        tbl[7]  = mk(0, 0, 0, 6, 0, 1, 6, 64'h40000000_00000000, 1, 1, 1, 64'h0, 64'h0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 6, 7, 0, 0, 64'h0, 0, 0, 1, 64'h40000000_00000000, 64'h0, 1, 0);
        tbl[9]  = mk(0, 0, 1, 6, 6, 1, 7, 64'h11111111_22222222, 0, 0, 1,
                     64'h40000000_00000000, 64'h40000000_00000000, 1, 0);
        tbl[10] = mk(0, 0, 1, 7, 6, 0, 0, 64'h0, 0, 0, 1,
                     64'h11111111_22222222, 64'h11111111_22222222, 1, 0);
        tbl[11] = mk(0, 0, 0, 7, 6, 0, 0, 64'h0, 1, 0, 1,
                     64'h22222222_00000000, 64'h11111111_00000000, 1, 0);
        tbl[12] = mk(0, 0, 0, 0, 1, 1, 0, 64'hAAAAAAAA_BBBBBBBB, 1, 1, 1, 64'h0, 64'h0, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 1, 0, 0, 64'h0, 0, 0, 1, 64'hAAAAAAAA_00000000, 64'h0, 1, 0);
        tbl[14] = mk(1, 0, 0, 0, 1, 1, 9, 64'hFFFFFFFF_FFFFFFFF, 1, 1, 1,
                     64'hAAAAAAAA_00000000, 64'h0, 1, 0);
        tbl[15] = mk(0, 0, 0, 0, 9, 0, 0, 64'h0, 0, 0, 1, 64'h0, 64'h0, 0, 0);
        tbl[16] = mk(0, 0, 1, 0, 0, 1, 6, 64'h12345678_9ABCDEF0, 0, 0, 1, 64'h0, 64'h0, 0, 0);
        tbl[17] = mk(0, 1, 1, 0, 7, 0, 0, 64'h0, 0, 0, 1, 64'h0, 64'h12345678_9ABCDEF0, 0, 0);
        tbl[18] = mk(0, 0, 1, 0, 7, 0, 0, 64'h0, 0, 0, 1, 64'h0, 64'h12345678_9ABCDEF0, 0, 1);

        apply(tbl[0], 0);
        for (int i = 0; i < 32; i++) begin
            for (int d = 0; d < 2; d++) begin
                apply(mk(0, 0, d[0], 5'(i), 5'(31 - i), 0, 0, 64'h0, 0, 0, 1,
                         64'h0, 64'h0, 0, 0), 100 + 2 * i + d);
            end
        end

        for (int k = 1; k < 19; k++) apply(tbl[k], k);

        // Sticky error must survive ten clean cycles.
        for (int k = 0; k < 10; k++)
            apply(mk(0, 0, 0, 0, 0, 0, 0, 64'h0, 0, 0, 1, 64'h0, 64'h0, 0, 1), 200 + k);

        // Odd DP index without inst_valid, and odd SP index with inst_valid, never flag.
        apply(mk(1, 0, 0, 0, 0, 0, 0, 64'h0, 0, 0, 1, 64'h0, 64'h0, 0, 1), 300);
        apply(mk(0, 0, 1, 0, 7, 0, 0, 64'h0, 0, 0, 1, 64'h0, 64'h0, 0, 0), 301);
        apply(mk(0, 1, 0, 3, 7, 0, 0, 64'h0, 0, 0, 1, 64'h0, 64'h0, 0, 0), 302);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 64'h0, 0, 0, 1, 64'h0, 64'h0, 0, 0), 303);

        // Odd DP write index flags the error yet still writes the forced-even pair.
        apply(mk(0, 1, 1, 2, 2, 1, 9, 64'hCAFEBABE_0BADF00D, 0, 0, 1, 64'h0, 64'h0, 0, 0), 304);
        apply(mk(0, 0, 1, 8, 9, 0, 0, 64'h0, 0, 0, 1,
                 64'hCAFEBABE_0BADF00D, 64'hCAFEBABE_0BADF00D, 0, 1), 305);
        apply(mk(0, 0, 0, 9, 8, 0, 0, 64'h0, 0, 0, 1,
                 64'h0BADF00D_00000000, 64'hCAFEBABE_00000000, 0, 1), 306);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
